// File: rtl/chart_read_arbiter.sv
// chart_read_arbiter
// Shares the single chart-ROM read port between page modules (menu name
// prefetch, play page, history page). One transaction at a time, granted
// round-robin; the owner gets a one-cycle ack while chart_data is valid.
//
// Ports:
//   clk     - program clock, rising edge
//   rst     - asynchronous active-high reset
//   req     - per-requester level request (index 0 menu, 1 play, 2 history)
//   req_id  - per-requester chart id, requester i on bits [8*i+7:8*i]
//   mem_id  - chart id driven to the ROM; holds after the transaction ends
//   grant   - one-hot owner of the current transaction, zero when idle
//   ack     - one-cycle pulse to the owner; chart_data valid this cycle
//   id_err  - pulses with ack when the granted id was out of range
//   busy    - high whenever a transaction is in flight
module chart_read_arbiter #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned NUM_CHARTS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_id,
    output logic [7:0]        mem_id,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic              id_err,
    output logic              busy
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [IdxW-1:0] win_q, win_d;
    logic            err_q, err_d;
    logic [7:0]      mem_id_q, mem_id_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            id_err_q, id_err_d;

    logic [IdxW-1:0] pick;
    logic            found;
    logic [7:0]      cur_id;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int unsigned j;
        j     = 0;
        pick  = last_q;
        found = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            j = (32'(last_q) + i) % NREQ;
            if (!found && req[IdxW'(j)]) begin
                pick  = IdxW'(j);
                found = 1'b1;
            end
        end
    end

    assign cur_id = req_id[8*32'(pick) +: 8];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;
        err_d    = err_q;
        mem_id_d = mem_id_q;
        grant_d  = grant_q;
        ack_d    = ack_q;
        id_err_d = id_err_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    win_d = pick;
                    // Out-of-range ids read chart 0 and flag the owner instead.
                    if (32'(cur_id) < NUM_CHARTS) begin
                        mem_id_d = cur_id;
                        err_d    = 1'b0;
                    end else begin
                        mem_id_d = 8'd0;
                        err_d    = 1'b1;
                    end
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    cnt_d         = CntW'(MEM_LAT);
                    state_d       = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    ack_d    = grant_q;
                    id_err_d = err_q;
                    state_d  = StAck;
                end
            end
            StAck: begin
                ack_d    = '0;
                grant_d  = '0;
                id_err_d = 1'b0;
                last_d   = win_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            last_q   <= IdxW'(NREQ - 1);
            win_q    <= '0;
            err_q    <= 1'b0;
            mem_id_q <= 8'd0;
            grant_q  <= '0;
            ack_q    <= '0;
            id_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            err_q    <= err_d;
            mem_id_q <= mem_id_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            id_err_q <= id_err_d;
        end
    end

    assign mem_id = mem_id_q;
    assign grant  = grant_q;
    assign ack    = ack_q;
    assign id_err = id_err_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_chart_read_arbiter.sv
// Bench for chart_read_arbiter: one instance with MEM_LAT=1 (dut_a) and one
// with MEM_LAT=4 (dut_b). Expected ack records go into a queue when a request
// is driven and are popped when an ack pulse appears.
module tb_chart_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [2:0]  req_a, req_b;
    logic [23:0] ids_a, ids_b;
    logic [7:0]  mem_id_a, mem_id_b;
    logic [2:0]  grant_a, grant_b, ack_a, ack_b;
    logic        err_a, err_b, busy_a, busy_b;

    always #5 clk = ~clk;

    chart_read_arbiter #(.NREQ(3), .MEM_LAT(1), .NUM_CHARTS(7)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .req_id(ids_a), .mem_id(mem_id_a),
        .grant(grant_a), .ack(ack_a), .id_err(err_a), .busy(busy_a)
    );

    chart_read_arbiter #(.NREQ(3), .MEM_LAT(4), .NUM_CHARTS(7)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .req_id(ids_b), .mem_id(mem_id_b),
        .grant(grant_b), .ack(ack_b), .id_err(err_b), .busy(busy_b)
    );

    typedef struct {
        logic [2:0]  req;
        logic [23:0] ids;
        logic [2:0]  exp_grant;
        logic [7:0]  exp_mem;
        logic        exp_err;
        int          idle;
    } vec_t;

    typedef struct {
        logic [2:0] grant;
        logic [7:0] mem_id;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic [7:0] mem_id;
        logic [2:0] grant;
        logic [2:0] ack;
        logic       id_err;
        logic       busy;
    } out_t;

    exp_t sbq[$];
    vec_t vecs[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit b, input logic [2:0] r, input logic [23:0] ids);
        if (b) begin
            req_b = r;
            ids_b = ids;
        end else begin
            req_a = r;
            ids_a = ids;
        end
    endtask

    function automatic out_t get_out(input bit b);
        out_t o;
        if (b) o = '{mem_id_b, grant_b, ack_b, err_b, busy_b};
        else   o = '{mem_id_a, grant_a, ack_a, err_a, busy_a};
        return o;
    endfunction

    // Pop the oldest expectation and compare it with the ack now visible.
    task automatic score(input bit b);
        out_t o;
        exp_t e;
        o = get_out(b);
        if (sbq.size() == 0) begin
            chk("unexpected_ack", 32'(o.ack), 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("ack_owner", 32'(o.ack), 32'(e.grant));
            chk("ack_grant", 32'(o.grant), 32'(e.grant));
            chk("ack_mem_id", 32'(o.mem_id), 32'(e.mem_id));
            chk("ack_id_err", 32'(o.id_err), 32'(e.err));
        end
    endtask

    task automatic wait_ack(input bit b, input int bound, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < bound) begin
            @(negedge clk);
            n++;
            if (get_out(b).ack != 3'b000) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: no ack within %0d cycles, required one", bound);
            if (sbq.size() != 0) void'(sbq.pop_front());
        end
    endtask

    // One transaction from idle: request held until ack, then idle cycles.
    task automatic run_txn(input bit b, input vec_t v, input int lat);
        out_t o;
        int   n;
        bit   seen;
        set_in(b, v.req, v.ids);
        sbq.push_back('{v.exp_grant, v.exp_mem, v.exp_err});
        @(negedge clk);
        o = get_out(b);
        chk("grant_at_e0", 32'(o.grant), 32'(v.exp_grant));
        chk("mem_id_at_e0", 32'(o.mem_id), 32'(v.exp_mem));
        chk("busy_at_e0", 32'(o.busy), 32'd1);
        wait_ack(b, 20, n, seen);
        if (seen) begin
            score(b);
            chk("ack_latency", 32'(n), 32'(lat));
        end
        set_in(b, 3'b000, v.ids);
        repeat (v.idle) begin
            @(negedge clk);
            o = get_out(b);
            chk("idle_mem_id", 32'(o.mem_id), 32'(v.exp_mem));
            chk("idle_grant", 32'(o.grant), 32'd0);
            chk("idle_ack", 32'(o.ack), 32'd0);
            chk("idle_busy", 32'(o.busy), 32'd0);
        end
    endtask

    initial begin
        out_t o;
        int   n, acks, last_ack, ack_cnt;
        bit   seen;

        //           req     ids {id2,id1,id0}        grant   mem    err  idle
        vecs[0] = '{3'b001, {8'd0, 8'd0, 8'd3},  3'b001, 8'd3, 1'b0, 1};
        vecs[1] = '{3'b010, {8'd0, 8'd5, 8'd0},  3'b010, 8'd5, 1'b0, 1};
        vecs[2] = '{3'b011, {8'd0, 8'd4, 8'd2},  3'b001, 8'd2, 1'b0, 1};
        vecs[3] = '{3'b100, {8'd9, 8'd0, 8'd0},  3'b100, 8'd0, 1'b1, 3};
        vecs[4] = '{3'b110, {8'd1, 8'd6, 8'd0},  3'b010, 8'd6, 1'b0, 1};
        vecs[5] = '{3'b101, {8'd0, 8'd0, 8'd7},  3'b100, 8'd0, 1'b0, 1};
        vecs[6] = '{3'b111, {8'd2, 8'd1, 8'd7},  3'b001, 8'd0, 1'b1, 1};
        vecs[7] = '{3'b100, {8'd5, 8'd0, 8'd0},  3'b100, 8'd5, 1'b0, 10};

        rst_a = 1'b1;
        rst_b = 1'b1;
        set_in(0, 3'b000, 24'd0);
        set_in(1, 3'b000, 24'd0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            o = get_out(k[0]);
            chk("reset_mem_id", 32'(o.mem_id), 32'd0);
            chk("reset_grant", 32'(o.grant), 32'd0);
            chk("reset_ack", 32'(o.ack), 32'd0);
            chk("reset_id_err", 32'(o.id_err), 32'd0);
            chk("reset_busy", 32'(o.busy), 32'd0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(0, vecs[i], 1);

        // Three-way contention, req held continuously; last winner was 2.
        set_in(0, 3'b111, {8'd3, 8'd2, 8'd1});
        sbq.push_back('{3'b001, 8'd1, 1'b0});
        sbq.push_back('{3'b010, 8'd2, 1'b0});
        sbq.push_back('{3'b100, 8'd3, 1'b0});
        sbq.push_back('{3'b001, 8'd1, 1'b0});
        n = 0;
        acks = 0;
        last_ack = 0;
        while (acks < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (ack_a != 3'b000) begin
                score(0);
                if (acks > 0) chk("ack_spacing", 32'(n - last_ack), 32'd3);
                last_ack = n;
                acks++;
            end
        end
        set_in(0, 3'b000, 24'd0);
        if (acks < 4) begin
            n_tests++;
            n_fail++;
            $display("FAIL contention_acks: got %0d acks, expected 4", acks);
        end
        sbq.delete();
        repeat (2) @(negedge clk);

        // MEM_LAT=4: requester drops req and changes id during WAIT.
        set_in(1, 3'b010, {8'd0, 8'd4, 8'd0});
        sbq.push_back('{3'b010, 8'd4, 1'b0});
        @(negedge clk);
        chk("wait_grant", 32'(grant_b), 32'b010);
        chk("wait_mem_id", 32'(mem_id_b), 32'd4);
        set_in(1, 3'b000, {8'd0, 8'd6, 8'd0});
        wait_ack(1, 20, n, seen);
        if (seen) begin
            score(1);
            chk("drop_ack_latency", 32'(n), 32'd4);
        end
        repeat (2) @(negedge clk);
        chk("drop_mem_hold", 32'(mem_id_b), 32'd4);

        // Reset in the second WAIT cycle discards the transaction.
        set_in(1, 3'b001, {8'd0, 8'd0, 8'd2});
        @(negedge clk);
        chk("pre_rst_grant", 32'(grant_b), 32'b001);
        @(negedge clk);
        rst_b = 1'b1;
        set_in(1, 3'b000, 24'd0);
        #1;
        chk("async_rst_mem_id", 32'(mem_id_b), 32'd0);
        chk("async_rst_grant", 32'(grant_b), 32'd0);
        chk("async_rst_ack", 32'(ack_b), 32'd0);
        chk("async_rst_busy", 32'(busy_b), 32'd0);
        chk("async_rst_id_err", 32'(err_b), 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        ack_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack_b != 3'b000) ack_cnt++;
        end
        chk("no_ack_after_reset", 32'(ack_cnt), 32'd0);

        // Reset restored priority to index 0, so requester 1 beats 2.
        run_txn(1, '{3'b110, {8'd2, 8'd3, 8'd0}, 3'b010, 8'd3, 1'b0, 2}, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chart_read_arbiter.md
# chart_read_arbiter

Shares the single chart-ROM read port (chart id in, `Chart` struct out) between page modules: the main menu's name prefetch, the play page and the history page. It accepts one request at a time and drives the shared `mem_id`. Grants go round-robin among pending requesters. It tells the winner exactly when the ROM output belongs to it.

## Interface
- `NREQ`, 3: number of requesters; index 0 = menu, 1 = play, 2 = history.
- `MEM_LAT`, 1: ROM read latency, in cycles from a `mem_id` change to valid `chart_data`; legal range 1..15.
- `NUM_CHARTS`, 7: valid chart ids are 0..NUM_CHARTS-1.
- `clk` input, 1: program clock, rising-edge.
- `rst` input, 1: asynchronous, active-high reset.
- `req` input, NREQ: per-requester level request.
- `req_id` input, 8*NREQ: requested chart id; requester i uses bits [8*i+7:8*i].
- `mem_id` output, 8: chart id driven to the ROM (the menu's `read_chart_id` role).
- `grant` output, NREQ: one-hot owner of the current transaction; all-zero when idle.
- `ack` output, NREQ: one-cycle pulse to the owner; `chart_data` is valid during this cycle.
- `id_err` output, 1: pulses with `ack` when the granted id was out of range.
- `busy` output, 1: high in any state other than IDLE.

## Operation
- State machine: IDLE -> WAIT -> ACK -> IDLE.
- **IDLE**
  - Sample `req`.
  - If any bit is set, choose the winner round-robin, searching from `last+1` (mod NREQ) upward.
  - At that edge, register `mem_id`, set `grant` one-hot, load `cnt` = MEM_LAT and go to WAIT.
  - If no bit is set, stay in IDLE. `mem_id` and `last` hold their values.
- **Id check:** if `req_id[winner]` >= NUM_CHARTS, drive `mem_id` = 0 and set an internal error flag.
- **WAIT:** decrement `cnt` each edge. The edge where `cnt` == 1 moves to ACK, asserts `ack[winner]`, and asserts `id_err` if the error flag is set.
- **ACK**
  - Lasts exactly one cycle.
  - At the next edge: clear `ack`, `grant` and `id_err`; set `last` = winner; go to IDLE.
- **Holding the ROM output:** `mem_id` holds after ACK until the next grant, so `chart_data` stays valid for the last owner while the arbiter is idle.
- **Requester rules:**
  - Hold `req` and `req_id` stable from assertion until `ack` is seen.
  - Deassert `req` at the edge that samples `ack`. A `req` still high in IDLE is a new request.
- **Requester drops `req` during WAIT:** the transaction still completes and `ack` still pulses. The arbiter takes no abort path.
- **`req_id` changes during WAIT:** ignored; `mem_id` was latched at grant.
- **Simultaneous requests:** exactly one grant per IDLE cycle. The losers stay pending and are served in rotation order.
- **Fairness:** no requester waits more than NREQ-1 transactions.

## Timing
- Reset values (asynchronous, active while `rst` = 1):
  - state = IDLE, `cnt` = 0, `last` = NREQ-1 (so index 0 has first priority).
  - `mem_id` = 0, `grant` = 0, `ack` = 0, `id_err` = 0, `busy` = 0.
- Reset during WAIT or ACK: the transaction is discarded, no `ack` is issued, and all outputs return to their reset values immediately.
- Let edge E0 be the first edge at which IDLE samples `req` high.
  - `mem_id` and `grant` update at E0.
  - `ack` goes high at E0+MEM_LAT and low at E0+MEM_LAT+1.
- `req` to `ack` latency: MEM_LAT+1 edges, from the IDLE-sampling edge inclusive.
- Back-to-back service: one transaction per MEM_LAT+2 cycles.
- All outputs are registered; no combinational path from `req` to any output.

## Test plan
- **Single request:** reset, then `req` = 001 with id 3 (MEM_LAT = 1).
  - `mem_id` = 3 and `grant` = 001 one edge later.
  - `ack` = 001 for exactly one cycle, one edge after that; `id_err` = 0; `busy` falls the following edge.
- **Three-way contention:** `req` = 111 held continuously, ids 1, 2, 3.
  - Grants go 001, 010, 100, 001, ...
  - `ack` pulses are spaced 3 cycles apart; `mem_id` sequence is 1, 2, 3, 1.
- **Rotation memory:** serve requester 1, then assert `req` = 011 together. Requester 0 must win next.
- **Out of range:** `req` = 100 with id 9.
  - `mem_id` = 0; `id_err` and `ack[2]` pulse together.
  - `mem_id` stays 0 through the following idle cycles.
- **Mid-transaction disturbances** (MEM_LAT = 4):
  - Requester drops `req` and changes its id during WAIT: `ack` still pulses 4 cycles after grant, and `mem_id` is unchanged.
  - Assert `rst` in the second WAIT cycle: all outputs go to 0 asynchronously, and no `ack` follows after release.
- **Stable hold:** after an `ack` for id 5, keep `req` low for 10 cycles. `mem_id` stays 5, `busy` stays 0, and `grant` stays 0.
